// File: rtl/uart_rx_byte_fifo.sv
// Show-ahead byte FIFO behind the UART receiver, with fill level and a sticky overflow flag.
// Defining UART_RX_FIFO_DROP_CNT_EN adds a saturating count of dropped bytes.
module uart_rx_byte_fifo #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_uart_dv,
  input  logic [DATA_WIDTH-1:0]      i_uart_data,
  output logic [DATA_WIDTH-1:0]      o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_overflow,
  input  logic                       i_clr_ovf,
  output logic [7:0]                 o_drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic                  overflow_r;
  logic                  full_s;
  logic                  valid_s;
  logic                  rd_en_s;
  logic                  wr_en_s;
  logic                  drop_s;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign full_s  = (count_r == CNT_DEPTH);
  assign valid_s = (count_r != {CW{1'b0}});
  assign rd_en_s = valid_s & i_ready;
  assign wr_en_s = i_uart_dv & (~full_s | rd_en_s);
  assign drop_s  = i_uart_dv & full_s & ~rd_en_s;

  // Storage array; cleared on reset so o_data reads zero afterwards.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (wr_en_s) begin
      mem_r[wr_ptr_r] <= i_uart_data;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      else         wr_ptr_r <= wr_ptr_r;
      if (rd_en_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      else         rd_ptr_r <= rd_ptr_r;
    end
  end

  // Fill level tracks the net effect of write and read each cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_r <= {CW{1'b0}};
    end else begin
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (i_clr_ovf) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

`ifdef UART_RX_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt_r;

  // Saturating drop counter, cleared alongside the overflow flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      drop_cnt_r <= 8'd0;
    end else if (drop_s) begin
      if (drop_cnt_r != 8'd255) drop_cnt_r <= drop_cnt_r + 8'd1;
      else                      drop_cnt_r <= drop_cnt_r;
    end else if (i_clr_ovf) begin
      drop_cnt_r <= 8'd0;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign o_drop_count = drop_cnt_r;
`else
  assign o_drop_count = 8'd0;
`endif

  assign o_data     = mem_r[rd_ptr_r];
  assign o_valid    = valid_s;
  assign o_count    = count_r;
  assign o_full     = full_s;
  assign o_overflow = overflow_r;

endmodule
